// File: rtl/imem_responder.sv
// Instruction memory with a NOP-fill clear phase, program-load write port and fetch port.
// Latency: fetch response and load ack both arrive exactly one cycle after the request.
// Backpressure: none per request; busy is high during the DEPTH-cycle clear, when all requests are dropped.
module imem_responder #(
    parameter logic [31:0] NOP_WORD = 32'h00000013,
    parameter int          DEPTH    = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [10:0] fetch_addr,
    output logic        fetch_valid,
    output logic [31:0] fetch_inst,
    output logic        fetch_misalign,
    input  logic        load_en,
    input  logic [8:0]  load_addr,
    input  logic [31:0] load_data,
    output logic        load_ack,
    output logic        busy
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [8:0]  clr_cnt;
    logic        clr_last;
    logic        fetch_acc;
    logic        load_acc;
    logic        mem_we;
    logic [8:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] mem [DEPTH];

    assign clr_last = (clr_cnt == 9'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_last) begin
            state_nxt = READY;
        end
    end

    // The clear sweep owns the write port in CLEAR; loads own it in READY.
    always_comb begin
        busy      = (state == CLEAR);
        fetch_acc = (state == READY) && fetch_req;
        load_acc  = (state == READY) && load_en;
        mem_we    = 1'b0;
        mem_waddr = load_addr;
        mem_wdata = load_data;
        if (!rst) begin
            if (state == CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt;
                mem_wdata = NOP_WORD;
            end else begin
                mem_we    = load_en;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= 9'd0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_last ? 9'd0 : clr_cnt + 9'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // The read samples mem before this edge's write lands, so a same-word load/fetch returns old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_valid    <= 1'b0;
            fetch_misalign <= 1'b0;
            fetch_inst     <= 32'h0;
            load_ack       <= 1'b0;
        end else begin
            fetch_valid    <= fetch_acc;
            fetch_misalign <= fetch_acc && (fetch_addr[1:0] != 2'b00);
            load_ack       <= load_acc;
            if (fetch_acc) begin
                fetch_inst <= (fetch_addr[1:0] != 2'b00) ? NOP_WORD : mem[fetch_addr[10:2]];
            end
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Randomised and directed bench for imem_responder against a word-array reference model.
module tb_imem_responder;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [10:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic        fetch_misalign;
    logic        load_en;
    logic [8:0]  load_addr;
    logic [31:0] load_data;
    logic        load_ack;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [512];

    imem_responder dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_valid    (fetch_valid),
        .fetch_inst     (fetch_inst),
        .fetch_misalign (fetch_misalign),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .load_ack       (load_ack),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 512; i++) model[i] = NOP;
    endtask

    // Counts busy-high cycles from the current point, expecting no responses meanwhile.
    task automatic wait_clear(input string tag);
        int n;
        int stray;
        n = 0;
        stray = 0;
        for (int i = 0; i < 600; i++) begin
            if (!busy) break;
            n++;
            if (fetch_valid || load_ack) stray++;
            tick();
        end
        n_checks++;
        if (n !== 512) begin
            n_fail++;
            $display("FAIL %s_busy_cycles: got %0d, expected 512", tag, n);
        end
        n_checks++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL %s_resp_during_clear: got %0d responses, expected 0", tag, stray);
        end
        n_checks++;
        if (fetch_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_transition_req_ignored: fetch_valid=%b, expected 0", tag, fetch_valid);
        end
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fetch_req = 1'b1; fetch_addr = 11'h0;
        load_en = 1'b1; load_addr = 9'd0; load_data = 32'hFFFF_FFFF;
        repeat (3) tick();
        n_checks++;
        if ({fetch_valid, fetch_misalign, load_ack, busy} !== 4'b0001 || fetch_inst !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: v=%b m=%b ack=%b busy=%b inst=%h, expected 0 0 0 1 00000000",
                     fetch_valid, fetch_misalign, load_ack, busy, fetch_inst);
        end
        load_en = 1'b0;
    endtask

    task automatic test_clear();
        rst = 1'b0;
        fetch_req = 1'b1; fetch_addr = 11'h000;
        wait_clear("clear");
        tick();
        fetch_req = 1'b0;
        n_checks++;
        if (fetch_valid !== 1'b1 || fetch_inst !== NOP || fetch_misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL first_fetch: v=%b inst=%h m=%b, expected 1 %h 0", fetch_valid, fetch_inst, fetch_misalign, NOP);
        end
    endtask

    task automatic test_load_fetch();
        load_en = 1'b1; load_addr = 9'd5; load_data = 32'hDEADBEEF;
        tick();
        load_en = 1'b0; model[5] = 32'hDEADBEEF;
        n_checks++;
        if (load_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ack: got %b, expected 1", load_ack);
        end
        fetch_req = 1'b1; fetch_addr = 11'h014;
        tick();
        fetch_req = 1'b0;
        n_checks++;
        if (fetch_valid !== 1'b1 || fetch_inst !== 32'hDEADBEEF || fetch_misalign !== 1'b0 || load_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL load_then_fetch: v=%b inst=%h m=%b ack=%b, expected 1 deadbeef 0 0",
                     fetch_valid, fetch_inst, fetch_misalign, load_ack);
        end
        tick();
        n_checks++;
        if (fetch_valid !== 1'b0 || fetch_misalign !== 1'b0 || fetch_inst !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL idle_hold: v=%b m=%b inst=%h, expected 0 0 deadbeef", fetch_valid, fetch_misalign, fetch_inst);
        end
    endtask

    task automatic test_misalign();
        fetch_req = 1'b1; fetch_addr = 11'h016;
        tick();
        fetch_req = 1'b0;
        n_checks++;
        if (fetch_valid !== 1'b1 || fetch_misalign !== 1'b1 || fetch_inst !== NOP) begin
            n_fail++;
            $display("FAIL misalign: v=%b m=%b inst=%h, expected 1 1 %h", fetch_valid, fetch_misalign, fetch_inst, NOP);
        end
    endtask

    task automatic test_same_cycle();
        load_en = 1'b1; load_addr = 9'd3; load_data = 32'h11111111;
        tick();
        load_data = 32'h22222222;
        fetch_req = 1'b1; fetch_addr = 11'h00C;
        tick();
        load_en = 1'b0;
        n_checks++;
        if (fetch_valid !== 1'b1 || fetch_inst !== 32'h11111111 || load_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_old_data: v=%b inst=%h ack=%b, expected 1 11111111 1", fetch_valid, fetch_inst, load_ack);
        end
        tick();
        fetch_req = 1'b0;
        model[3] = 32'h22222222;
        n_checks++;
        if (fetch_valid !== 1'b1 || fetch_inst !== 32'h22222222) begin
            n_fail++;
            $display("FAIL same_cycle_new_data: v=%b inst=%h, expected 1 22222222", fetch_valid, fetch_inst);
        end
    endtask

    task automatic test_stream();
        logic [10:0] addrs [3];
        logic [8:0]  words [3];
        addrs[0] = 11'h7F8; addrs[1] = 11'h7FC; addrs[2] = 11'h000;
        words[0] = 9'd510;  words[1] = 9'd511;  words[2] = 9'd0;
        for (int i = 0; i < 3; i++) begin
            load_en = 1'b1; load_addr = words[i]; load_data = $urandom;
            model[words[i]] = load_data;
            tick();
        end
        load_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch_req = 1'b1; fetch_addr = addrs[i];
            tick();
            n_checks++;
            if (fetch_valid !== 1'b1 || fetch_inst !== model[words[i]] || fetch_misalign !== 1'b0) begin
                n_fail++;
                $display("FAIL stream_%0d: v=%b inst=%h m=%b, expected 1 %h 0", i, fetch_valid, fetch_inst, fetch_misalign, model[words[i]]);
            end
        end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] exp_inst;
        logic        exp_v;
        logic        exp_m;
        logic        exp_ack;
        exp_inst = fetch_inst;
        for (int c = 0; c < 300; c++) begin
            fetch_req  = ($urandom_range(0, 3) != 0);
            fetch_addr = {($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 7)) : 9'($urandom), 2'b00};
            if ($urandom_range(0, 3) == 0) fetch_addr[1:0] = 2'($urandom);
            load_en    = ($urandom_range(0, 1) == 0);
            load_addr  = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 7)) : 9'($urandom);
            load_data  = $urandom;
            exp_v   = fetch_req;
            exp_m   = fetch_req && (fetch_addr[1:0] != 2'b00);
            exp_ack = load_en;
            if (fetch_req) exp_inst = exp_m ? NOP : model[fetch_addr[10:2]];
            if (load_en) model[load_addr] = load_data;
            tick();
            n_checks++;
            if (fetch_valid !== exp_v || fetch_misalign !== exp_m || fetch_inst !== exp_inst || load_ack !== exp_ack) begin
                n_fail++;
                $display("FAIL random_c%0d: v=%b m=%b inst=%h ack=%b, expected %b %b %h %b",
                         c, fetch_valid, fetch_misalign, fetch_inst, load_ack, exp_v, exp_m, exp_inst, exp_ack);
            end
        end
        fetch_req = 1'b0; load_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        load_en = 1'b1; load_addr = 9'd7; load_data = 32'hCAFEF00D;
        tick();
        load_en = 1'b0;
        fetch_req = 1'b1; fetch_addr = 11'h01C;
        tick();
        n_checks++;
        if (fetch_inst !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL pre_reset_word7: got %h, expected cafef00d", fetch_inst);
        end
        rst = 1'b1; load_en = 1'b1; load_data = 32'h0BAD0BAD;
        tick();
        n_checks++;
        if ({fetch_valid, fetch_misalign, load_ack, busy} !== 4'b0001 || fetch_inst !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_state: v=%b m=%b ack=%b busy=%b inst=%h, expected 0 0 0 1 00000000",
                     fetch_valid, fetch_misalign, load_ack, busy, fetch_inst);
        end
        tick();
        rst = 1'b0; load_en = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_clear("reclear");
        tick();
        fetch_req = 1'b0;
        n_checks++;
        if (fetch_valid !== 1'b1 || fetch_inst !== NOP) begin
            n_fail++;
            $display("FAIL post_reset_word7: v=%b inst=%h, expected 1 %h", fetch_valid, fetch_inst, NOP);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_clear();
        test_load_fetch();
        test_misalign();
        test_same_cycle();
        test_stream();
        test_random();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter NOP_WORD, default 32'h00000013, is the fill and substitute instruction (RV32 addi x0,x0,0).
REQ-002 Parameter DEPTH, default 512, is the number of 32-bit instruction words held; the fetch address is 11-bit byte-addressed.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port fetch_req  input  1  is asserted by the program counter side to request one instruction.
REQ-006 Port fetch_addr  input  11  is the byte address of the requested instruction.
REQ-007 Port fetch_valid  output  1  is a one-cycle pulse marking a fetch response.
REQ-008 Port fetch_inst  output  32  is the returned instruction word.
REQ-009 Port fetch_misalign  output  1  flags a response to an address with fetch_addr[1:0] != 0, qualified by fetch_valid.
REQ-010 Port load_en  input  1  is the program-load write strobe.
REQ-011 Port load_addr  input  9  is the word index for a program-load write.
REQ-012 Port load_data  input  32  is the instruction word to store.
REQ-013 Port load_ack  output  1  is a one-cycle pulse confirming that a load write was accepted.
REQ-014 Port busy  output  1  is high while the block cannot accept fetch or load requests.

Function
REQ-015 The FSM shall have exactly two states: CLEAR and READY.
REQ-016 In CLEAR, a 9-bit clear counter shall write NOP_WORD to one word per cycle, from index 0 up to DEPTH-1.
REQ-017 After the write to index DEPTH-1, the FSM shall enter READY on the next edge; CLEAR lasts exactly DEPTH cycles.
REQ-018 busy shall be 1 in CLEAR and 0 in READY.
REQ-019 In CLEAR, fetch_req and load_en shall be ignored: no response, no ack, no write.
REQ-020 In READY, fetch_req=1 at edge N shall produce fetch_valid=1 at edge N+1, for fixed 1-cycle latency.
REQ-021 The response to an aligned request shall be fetch_inst = mem[fetch_addr[10:2]] with fetch_misalign=0.
REQ-022 The response to a misaligned request shall be fetch_valid=1, fetch_misalign=1 and fetch_inst=NOP_WORD, with no memory read side effect.
REQ-023 Back-to-back requests on every cycle shall be accepted with no bubbles: one response per request.
REQ-024 fetch_inst shall hold its last value when fetch_valid=0; fetch_misalign shall be 0 whenever fetch_valid=0.
REQ-025 In READY, load_en=1 at edge N shall write load_data to mem[load_addr] at edge N and pulse load_ack at edge N+1.
REQ-026 A load and a fetch in the same cycle shall both be serviced.
REQ-027 If the load and fetch in the same cycle target the same word, the fetch shall return the pre-write (old) data.
REQ-028 fetch_addr shall span exactly 512 words; no out-of-range case exists. Address 11'h7FC shall return word 511, and 11'h000 shall return word 0.
REQ-029 Requests arriving on the edge where the FSM moves from CLEAR to READY shall be ignored; the first request accepted is on the following edge.

Reset
REQ-030 When rst=1 at an edge, the FSM shall enter CLEAR with the clear counter at 0, and fetch_valid=0, fetch_misalign=0, load_ack=0, fetch_inst=32'h0, busy=1.
REQ-031 Reset during READY or mid-CLEAR shall discard any pending response or ack and restart the full DEPTH-cycle clear.
REQ-032 While rst stays high, the block shall hold the reset state and perform no memory writes.

Verification
REQ-033 Release reset, then hold fetch_req=1 at addr 0 -> busy=1 for 512 cycles, no fetch_valid during that time; first response returns 32'h00000013.
REQ-034 Load word 5 = 32'hDEADBEEF -> load_ack pulses next cycle; fetch addr 11'h014 -> fetch_valid one cycle later with fetch_inst=32'hDEADBEEF, fetch_misalign=0.
REQ-035 Fetch addr 11'h016 -> fetch_valid=1, fetch_misalign=1, fetch_inst=32'h00000013.
REQ-036 Word 3 = 32'h11111111; in the same cycle, load word 3 = 32'h22222222 and fetch 11'h00C -> response 32'h11111111; the next fetch of 11'h00C returns 32'h22222222.
REQ-037 Streaming fetches of 11'h7F8 then 11'h7FC then 11'h000 -> three consecutive valid pulses returning words 510, 511 and 0.
REQ-038 Assert rst mid-stream after loading word 7 -> outputs zeroed, busy=1 for 512 cycles, and a subsequent fetch of 11'h01C returns 32'h00000013.
